// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: load-multiple / store-multiple micro-sequencer.
// Walks a latched 8-bit register mask from R0 upward, moving one 16-bit
// word per ACTIVE cycle between the register file and data memory at
// consecutive addresses, then pulses done for one cycle.
module lmsm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [15:0] base_addr,
  input  logic [7:0]  reg_mask,
  input  logic [15:0] rf_rd_data,
  input  logic [15:0] mem_rd_data,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr_en,
  output logic [15:0] mem_wr_data,
  output logic [2:0]  rf_rd_sel,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_sel,
  output logic [15:0] rf_wr_data,
  output logic        stall,
  output logic        done,
  output logic [3:0]  xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_ptr;
  logic [7:0]  r_mask;
  logic        r_is_store;
  logic [3:0]  r_count;

  logic [2:0]  w_idx;
  logic [7:0]  w_mask_next;

  // Index of the lowest set bit; an empty mask yields 0 (never used in ACTIVE).
  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        idx = i[2:0];
      end
    end
    return idx;
  endfunction

  assign w_idx       = lowest_idx(r_mask);
  // Clearing the lowest set bit is the same as clearing bit w_idx.
  assign w_mask_next = r_mask & (r_mask - 8'd1);

  // Sequencer state, address pointer, pending mask and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= 16'd0;
      r_mask     <= 8'd0;
      r_is_store <= 1'b0;
      r_count    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_store <= is_store;
            r_ptr      <= base_addr;
            r_mask     <= reg_mask;
            r_count    <= 4'd0;
            r_state    <= (reg_mask != 8'd0) ? S_ACTIVE : S_DONE;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_ACTIVE: begin
          // One word per cycle; pointer wraps modulo 2^16 silently.
          r_mask  <= w_mask_next;
          r_ptr   <= r_ptr + 16'd1;
          r_count <= r_count + 4'd1;
          if (w_mask_next == 8'd0) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_ACTIVE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: everything is quiet outside ACTIVE except the done pulse;
  // the data paths pass straight through in the transfer cycle.
  always_comb begin
    mem_addr    = 16'd0;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 16'd0;
    rf_rd_sel   = 3'd0;
    rf_wr_en    = 1'b0;
    rf_wr_sel   = 3'd0;
    rf_wr_data  = 16'd0;
    stall       = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        mem_en   = 1'b1;
        mem_addr = r_ptr;
        stall    = 1'b1;
        if (r_is_store) begin
          mem_wr_en   = 1'b1;
          rf_rd_sel   = w_idx;
          mem_wr_data = rf_rd_data;
        end else begin
          rf_wr_en    = 1'b1;
          rf_wr_sel   = w_idx;
          rf_wr_data  = mem_rd_data;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign xfer_count = r_count;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed testbench for lmsm_sequencer with hand-computed expectations.
module tb_lmsm_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic [15:0] rf_rd_data;
  logic [15:0] mem_rd_data;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [2:0]  rf_rd_sel;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_sel;
  logic [15:0] rf_wr_data;
  logic        stall;
  logic        done;
  logic [3:0]  xfer_count;

  logic [15:0] regs [8];
  int          n_tests;
  int          n_fail;

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_mask(reg_mask), .rf_rd_data(rf_rd_data),
    .mem_rd_data(mem_rd_data), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .rf_rd_sel(rf_rd_sel),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
    .stall(stall), .done(done), .xfer_count(xfer_count)
  );

  // Register-file model: combinational read.
  assign rf_rd_data = regs[rf_rd_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_mem_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    check({tag, "_rf_wr_en"}, {31'd0, rf_wr_en}, 32'd0);
    check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
  endtask

  task automatic go(input logic st, input logic [15:0] ba, input logic [7:0] m);
    is_store  = st;
    base_addr = ba;
    reg_mask  = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0100 + 16'(i);
    regs[0] = 16'h1111;
    regs[2] = 16'h2222;
    reset = 1'b1; start = 1'b0; is_store = 1'b0;
    base_addr = 16'd0; reg_mask = 8'd0; mem_rd_data = 16'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check_quiet("rst");
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_xfer", {28'd0, xfer_count}, 32'd0);
    check("rst_wdata", {16'd0, mem_wr_data}, 32'd0);

    // SM: base 10, mask 0x05
    go(1'b1, 16'd10, 8'h05);
    check("sm1_addr", {16'd0, mem_addr}, 32'd10);
    check("sm1_wr", {31'd0, mem_wr_en}, 32'd1);
    check("sm1_data", {16'd0, mem_wr_data}, 32'h1111);
    check("sm1_sel", {29'd0, rf_rd_sel}, 32'd0);
    check("sm1_rfwe", {31'd0, rf_wr_en}, 32'd0);
    check("sm1_stall", {31'd0, stall}, 32'd1);
    tick();
    check("sm2_addr", {16'd0, mem_addr}, 32'd11);
    check("sm2_data", {16'd0, mem_wr_data}, 32'h2222);
    check("sm2_sel", {29'd0, rf_rd_sel}, 32'd2);
    tick();
    check("sm_done", {31'd0, done}, 32'd1);
    check("sm_xfer", {28'd0, xfer_count}, 32'd2);
    check_quiet("sm_dq");
    tick();
    check("sm_idle_done", {31'd0, done}, 32'd0);
    check("sm_hold_xfer", {28'd0, xfer_count}, 32'd2);

    // LM: start in the IDLE cycle right after DONE; base 23, mask 0x80
    mem_rd_data = 16'd5;
    go(1'b0, 16'd23, 8'h80);
    check("lm_rfwe", {31'd0, rf_wr_en}, 32'd1);
    check("lm_sel", {29'd0, rf_wr_sel}, 32'd7);
    check("lm_data", {16'd0, rf_wr_data}, 32'd5);
    check("lm_memwe", {31'd0, mem_wr_en}, 32'd0);
    check("lm_addr", {16'd0, mem_addr}, 32'd23);
    check("lm_xfer0", {28'd0, xfer_count}, 32'd0);
    tick();
    check("lm_done", {31'd0, done}, 32'd1);
    check("lm_memwe_d", {31'd0, mem_wr_en}, 32'd0);
    check("lm_xfer", {28'd0, xfer_count}, 32'd1);
    tick();

    // Empty mask
    go(1'b1, 16'h0044, 8'h00);
    check("empty_done", {31'd0, done}, 32'd1);
    check_quiet("empty");
    check("empty_xfer", {28'd0, xfer_count}, 32'd0);
    tick();
    check("empty_idle", {31'd0, done}, 32'd0);

    // Wrap
    go(1'b1, 16'hFFFF, 8'h03);
    check("wrap_a0", {16'd0, mem_addr}, 32'h0000FFFF);
    tick();
    check("wrap_a1", {16'd0, mem_addr}, 32'h00000000);
    check("wrap_en1", {31'd0, mem_en}, 32'd1);
    check("wrap_sel1", {29'd0, rf_rd_sel}, 32'd1);
    tick();
    check("wrap_done", {31'd0, done}, 32'd1);
    tick();

    // Full mask LM with a start pulse in cycle 4
    mem_rd_data = 16'hA5A5;
    go(1'b0, 16'h0200, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      check("full_sel", {29'd0, rf_wr_sel}, i);
      check("full_stall", {31'd0, stall}, 32'd1);
      check("full_addr", {16'd0, mem_addr}, 32'h200 + i);
      check("full_data", {16'd0, rf_wr_data}, 32'hA5A5);
      if (i == 3) begin
        start = 1'b1; is_store = 1'b1; base_addr = 16'h0999; reg_mask = 8'h01;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("full_done", {31'd0, done}, 32'd1);
    check("full_xfer", {28'd0, xfer_count}, 32'd8);
    tick();
    check("full_idle", {31'd0, stall}, 32'd0);
    check("full_idle_done", {31'd0, done}, 32'd0);

    // Reset after the 2nd word
    go(1'b0, 16'h0300, 8'hFF);
    check("rs_w0", {29'd0, rf_wr_sel}, 32'd0);
    tick();
    check("rs_w1", {29'd0, rf_wr_sel}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("rs");
    check("rs_done", {31'd0, done}, 32'd0);
    check("rs_xfer", {28'd0, xfer_count}, 32'd0);
    tick();
    check("rs_nodone", {31'd0, done}, 32'd0);
    check_quiet("rs2");
    go(1'b1, 16'd5, 8'h02);
    check("rs_new_sel", {29'd0, rf_rd_sel}, 32'd1);
    check("rs_new_addr", {16'd0, mem_addr}, 32'd5);
    check("rs_new_data", {16'd0, mem_wr_data}, 32'h0101);
    tick();
    check("rs_new_done", {31'd0, done}, 32'd1);
    check("rs_new_xfer", {28'd0, xfer_count}, 32'd1);
    tick();

    // Reset and start together: reset wins
    reset = 1'b1;
    go(1'b1, 16'd7, 8'h01);
    reset = 1'b0;
    check_quiet("rsst");
    tick();
    check("rsst_done", {31'd0, done}, 32'd0);
    check("rsst_xfer", {28'd0, xfer_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
